online_result_collector: RTL and testbench

- Receiving end of the radix-2 online multiplier's serial output: captures the MSD-first signed-digit stream `z` and drops the delta warm-up digits.
- Converts the remaining digits on the fly into a parallel two's-complement result.
- Presents that result on a valid/ready handshake to downstream parallel logic.
- Runs in lock-step with the multiplier: the same start cycle, the same `full_result_sel` meaning.

---
 rtl/online_result_collector.sv | 139 +++++++++++++
 tb/tb_online_result_collector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/online_result_collector.sv
// Collects the MSD-first signed-digit stream of the radix-2 online multiplier and
// converts it on the fly into a two's-complement result. Optional: ONLINE_COLLECT_DIGIT_CHECK_EN.
module online_result_collector #(
  parameter int no_of_digits = 4,
  parameter int radix_bits   = 2,
  parameter int radix        = 2,
  parameter int delta        = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    full_result_sel,
  input  logic [radix_bits-1:0]   z_in,
  output logic [2*no_of_digits:0] result,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    busy,
  output logic                    start_drop,
  output logic                    digit_err
);
  localparam int W     = 2*no_of_digits + 1;
  localparam int CW    = $clog2(2*no_of_digits + delta + 2);
  localparam int SHIFT = $clog2(radix);
  localparam logic [radix_bits-1:0] DIG_POS = radix_bits'(1);
  localparam logic [radix_bits-1:0] DIG_NEG = {radix_bits{1'b1}};
  localparam logic [CW-1:0] ONE         = CW'(1);
  localparam logic [CW-1:0] SKIP_LAST   = CW'(delta > 0 ? delta - 1 : 0);
  localparam logic [CW-1:0] K_LAST_RED  = CW'(no_of_digits - 1);
  localparam logic [CW-1:0] K_LAST_FULL = CW'(2*no_of_digits - 1);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_COLLECT, S_HOLD} state_t;

  state_t        state_q;
  logic [W-1:0]  q_q, qm_q, q_d, qm_d, q_base, qm_base, result_q;
  logic [CW-1:0] cnt_q, cnt_cap, k_last;
  logic          full_sel_q, valid_q, busy_q, drop_q;
  logic          accept, cap, in_open, dig_pos, dig_neg;

  always_comb begin
    in_open = (state_q == S_IDLE) || (state_q == S_HOLD);
    accept  = start && ((state_q == S_IDLE) || ((state_q == S_HOLD) && result_ready));
    // With zero online delay the digit in the start cycle is already a result digit.
    cap     = (state_q == S_COLLECT) || (accept && (delta == 0));
    cnt_cap = (state_q == S_COLLECT) ? cnt_q : CW'(0);
    if (state_q == S_COLLECT) k_last = full_sel_q ? K_LAST_FULL : K_LAST_RED;
    else                      k_last = full_result_sel ? K_LAST_FULL : K_LAST_RED;
    q_base  = in_open ? '0 : q_q;
    qm_base = in_open ? '1 : qm_q;
    dig_pos = (z_in == DIG_POS);
    dig_neg = (z_in == DIG_NEG);
    if (dig_pos) begin
      q_d  = (q_base << SHIFT) | W'(1);
      qm_d = q_base << SHIFT;
    end else if (dig_neg) begin
      q_d  = (qm_base << SHIFT) | W'(1);
      qm_d = qm_base << SHIFT;
    end else begin
      q_d  = q_base << SHIFT;
      qm_d = (qm_base << SHIFT) | W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      q_q        <= '0;
      qm_q       <= '1;
      result_q   <= '0;
      cnt_q      <= '0;
      full_sel_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      if (start && !accept) drop_q <= 1'b1;
      case (state_q)
        S_SKIP: begin
          cnt_q <= cnt_q + ONE;
          if (cnt_q == SKIP_LAST) begin
            state_q <= S_COLLECT;
            cnt_q   <= '0;
          end
        end
        S_HOLD: begin
          if (result_ready) begin
            valid_q <= 1'b0;
            q_q     <= '0;
            qm_q    <= '1;
            state_q <= S_IDLE;
          end
        end
        default: begin
        end
      endcase
      // Index 0 is consumed by the accepting edge itself, so the count starts at 1.
      if (accept) begin
        full_sel_q <= full_result_sel;
        busy_q     <= 1'b1;
        q_q        <= '0;
        qm_q       <= '1;
        state_q    <= (delta <= 1) ? S_COLLECT : S_SKIP;
        cnt_q      <= (delta <= 1) ? CW'(0) : ONE;
      end
      if (cap) begin
        q_q   <= q_d;
        qm_q  <= qm_d;
        cnt_q <= cnt_cap + ONE;
        if (cnt_cap == k_last) begin
          result_q <= q_d;
          valid_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_HOLD;
        end else begin
          state_q  <= S_COLLECT;
        end
      end
    end
  end

`ifdef ONLINE_COLLECT_DIGIT_CHECK_EN
  localparam logic [radix_bits-1:0] DIG_ILL = DIG_POS << (radix_bits - 1);
  logic err_q;

  always_ff @(posedge clk) begin
    if (!reset_n)                   err_q <= 1'b0;
    else if (cap && z_in == DIG_ILL) err_q <= 1'b1;
  end

  assign digit_err = err_q;
`else
  assign digit_err = 1'b0;
`endif

  assign result       = result_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;
  assign start_drop   = drop_q;

endmodule

// File: tb/tb_online_result_collector.sv
// Self-checking bench for online_result_collector (N = 4, delta = 3) with a
// digit-sum reference model; honours ONLINE_COLLECT_DIGIT_CHECK_EN when defined.
module tb_online_result_collector;
  localparam int N     = 4;
  localparam int DELTA = 3;
  localparam int W     = 2*N + 1;
`ifdef ONLINE_COLLECT_DIGIT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         full_result_sel = 1'b0;
  logic         result_ready = 1'b0;
  logic [1:0]   z_in = 2'b00;
  logic [W-1:0] result;
  logic         result_valid, busy, start_drop, digit_err;

  int           errors = 0;
  int           checks = 0;
  logic [1:0]   dg [0:15];
  bit           exp_err = 1'b0;
  bit           exp_drop = 1'b0;
  logic [W-1:0] last_res = '0;

  always #5 clk = ~clk;

  online_result_collector #(.no_of_digits(N), .radix_bits(2), .radix(2), .delta(DELTA)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .full_result_sel(full_result_sel),
    .z_in(z_in), .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .start_drop(start_drop), .digit_err(digit_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Value of the first k collected digits: sum d_j * 2^(k-1-j), wrapped to W bits.
  function automatic logic [W-1:0] ref_val(input int k);
    int v;
    v = 0;
    for (int j = 0; j < k; j++)
      v = 2*v + ((dg[j] == 2'b01) ? 1 : ((dg[j] == 2'b11) ? -1 : 0));
    return W'(v);
  endfunction

  // Starts an operation now and feeds warm-up plus collected digits; ends just after
  // the edge where the result must become valid.
  task automatic feed_op(input bit full, input bit drop_mid);
    int k;
    logic [W-1:0] exp;
    k   = full ? 2*N : N;
    exp = ref_val(k);
    start = 1'b1;
    full_result_sel = full;
    for (int i = 0; i < DELTA + k; i++) begin
      if (i < DELTA) z_in = 2'($urandom_range(0, 3));
      else           z_in = dg[i-DELTA];
      if (i >= DELTA && CHK && z_in == 2'b10) exp_err = 1'b1;
      if (drop_mid && i == DELTA + 1) begin
        start = 1'b1;
        exp_drop = 1'b1;
      end
      tick;
      start = 1'b0;
      full_result_sel = 1'($urandom_range(0, 1));
      if (i == 0) begin
        result_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
          errors++;
          $display("FAIL accept: busy=%b valid=%b, expected busy=1 valid=0", busy, result_valid);
        end
      end
      if (i == DELTA + k - 2) begin
        checks++;
        if (result_valid !== 1'b0) begin
          errors++;
          $display("FAIL early_valid: valid=%b one cycle before latency, expected 0", result_valid);
        end
      end
    end
    checks++;
    if (result_valid !== 1'b1 || result !== exp) begin
      errors++;
      $display("FAIL result: valid=%b result=%h, expected valid=1 result=%h", result_valid, result, exp);
    end
    checks++;
    if (busy !== 1'b0 || digit_err !== exp_err || start_drop !== exp_drop) begin
      errors++;
      $display("FAIL flags: busy=%b digit_err=%b start_drop=%b, expected 0 %b %b",
               busy, digit_err, start_drop, exp_err, exp_drop);
    end
    last_res = exp;
  endtask

  task automatic hold_check(input int hold, input bit drop_in_hold);
    for (int c = 0; c < hold; c++) begin
      result_ready = 1'b0;
      if (drop_in_hold && c == hold/2) begin
        start = 1'b1;
        exp_drop = 1'b1;
      end
      tick;
      start = 1'b0;
      checks++;
      if (result_valid !== 1'b1 || result !== last_res) begin
        errors++;
        $display("FAIL hold: valid=%b result=%h, expected valid=1 result=%h", result_valid, result, last_res);
      end
    end
    checks++;
    if (start_drop !== exp_drop) begin
      errors++;
      $display("FAIL start_drop: got %b expected %b", start_drop, exp_drop);
    end
  endtask

  task automatic release_res;
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || result !== last_res || busy !== 1'b0) begin
      errors++;
      $display("FAIL release: valid=%b result=%h busy=%b, expected 0 %h 0", result_valid, result, busy, last_res);
    end
  endtask

  task automatic set_dg(input logic [1:0] d0, d1, d2, d3);
    dg[0] = d0; dg[1] = d1; dg[2] = d2; dg[3] = d3;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick; tick;
    checks++;
    if (result !== '0 || result_valid !== 1'b0 || busy !== 1'b0 || start_drop !== 1'b0 || digit_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: result=%h valid=%b busy=%b drop=%b err=%b, expected all 0",
               result, result_valid, busy, start_drop, digit_err);
    end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_reduced;
    set_dg(2'b01, 2'b00, 2'b11, 2'b01);
    feed_op(1'b0, 1'b0);
    release_res;
  endtask

  task automatic test_negative;
    set_dg(2'b11, 2'b00, 2'b00, 2'b00);
    feed_op(1'b0, 1'b0);
    release_res;
    for (int j = 0; j < 2*N; j++) dg[j] = 2'b11;
    feed_op(1'b1, 1'b0);
    release_res;
  endtask

  task automatic test_full;
    for (int j = 0; j < 2*N; j++) dg[j] = 2'b01;
    feed_op(1'b1, 1'b0);
    release_res;
  endtask

  task automatic test_back_to_back;
    set_dg(2'b01, 2'b11, 2'b01, 2'b00);
    feed_op(1'b0, 1'b0);
    hold_check(5, 1'b1);
    set_dg(2'b00, 2'b01, 2'b01, 2'b11);
    result_ready = 1'b1;
    feed_op(1'b0, 1'b0);
    release_res;
  endtask

  task automatic test_illegal;
    set_dg(2'b01, 2'b10, 2'b01, 2'b01);
    feed_op(1'b0, 1'b0);
    release_res;
    set_dg(2'b00, 2'b00, 2'b01, 2'b11);
    feed_op(1'b0, 1'b0);
    release_res;
  endtask

  task automatic test_reset_mid;
    set_dg(2'b01, 2'b11, 2'b01, 2'b01);
    start = 1'b1;
    full_result_sel = 1'b0;
    for (int i = 0; i < DELTA + 2; i++) begin
      z_in = (i < DELTA) ? 2'b00 : dg[i-DELTA];
      tick;
      start = 1'b0;
    end
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    exp_err = 1'b0;
    exp_drop = 1'b0;
    checks++;
    if (result !== '0 || result_valid !== 1'b0 || busy !== 1'b0 || start_drop !== 1'b0 || digit_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: result=%h valid=%b busy=%b drop=%b err=%b, expected all 0",
               result, result_valid, busy, start_drop, digit_err);
    end
    set_dg(2'b01, 2'b01, 2'b01, 2'b01);
    feed_op(1'b0, 1'b0);
    release_res;
  endtask

  task automatic test_random;
    int r;
    bit full;
    bit b2b;
    b2b = 1'b0;
    for (int it = 0; it < 24; it++) begin
      full = 1'($urandom_range(0, 1));
      for (int j = 0; j < 2*N; j++) begin
        r = $urandom_range(0, 9);
        dg[j] = (r == 0) ? 2'b10 : ((r < 4) ? 2'b01 : ((r < 7) ? 2'b11 : 2'b00));
      end
      if (b2b) result_ready = 1'b1;
      feed_op(full, ($urandom_range(0, 4) == 0));
      hold_check($urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      b2b = (it != 23) && ($urandom_range(0, 1) == 1);
      if (!b2b) release_res;
    end
  endtask

  initial begin
    test_reset;
    test_reduced;
    test_negative;
    test_full;
    test_back_to_back;
    test_illegal;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
